// File: rtl/calc_n.sv
// calc_n: NDIG-digit decimal calculator (+,-,*,/) with serial BCD scan-out of every result.
// Define CALC_DIV_EN to build the restoring divider; without it cmd 13 drives the block to ERR.
module calc_n #(
  parameter int NDIG = 8,
  parameter int DW   = 27
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [3:0]              cmd,
  input  logic                    cmd_valid,
  output logic [1:0]              status,
  output logic [3:0]              data,
  output logic [$clog2(NDIG)-1:0] pos,
  output logic                    disp_valid
);
  localparam int PW = $clog2(NDIG);
  localparam int CW = $clog2(DW);

  localparam logic [3:0] OP_ADD = 4'd10;
  localparam logic [3:0] OP_SUB = 4'd11;
  localparam logic [3:0] OP_MUL = 4'd12;
  localparam logic [3:0] OP_DIV = 4'd13;
  localparam logic [3:0] C_EQ   = 4'd14;
  localparam logic [3:0] C_BS   = 4'd15;

  localparam logic [1:0] ST_ERR   = 2'b00;
  localparam logic [1:0] ST_BUSY  = 2'b01;
  localparam logic [1:0] ST_READY = 2'b10;

  function automatic logic [DW-1:0] pow10(input int n);
    logic [DW-1:0] v;
    v = DW'(1);
    for (int i = 0; i < n; i++) v = v * DW'(10);
    return v;
  endfunction

  localparam logic [DW-1:0] MAXV = pow10(NDIG) - DW'(1);
  localparam logic [DW-1:0] LIMV = pow10(NDIG - 1);

  typedef enum logic [2:0] {ENTRY_A, ENTRY_B, EXEC, SCAN, ERR} state_t;

  state_t          state_q, ret_q;
  logic [1:0]      status_q;
  logic [3:0]      data_q;
  logic [PW-1:0]   pos_q;
  logic            dv_q;
  logic [DW-1:0]   rega_q, regb_q, entry_q, scan_q;
  logic [3:0]      op_q;
  logic [CW-1:0]   iter_q;
  logic [2*DW-1:0] prod_q;
  logic            fresh_q;

  logic            accept;
  logic            op_bad;
  logic [DW-1:0]   digit_d, bksp_d, res_d;
  logic [DW:0]     add_d, mul_hi;
  logic [2*DW-1:0] mul_d, div_d;
  logic            res_err_d, done_d, last_iter;
  logic [3:0]      scan_dig;

  assign accept    = cmd_valid && (status_q == ST_READY);
  assign last_iter = (iter_q == CW'(DW - 1));
  assign scan_dig  = 4'(scan_q % DW'(10));

  // A result sitting in the entry register is replaced, not extended, by the next digit.
  assign digit_d = fresh_q            ? DW'(cmd) :
                   (entry_q >= LIMV)  ? entry_q  :
                   entry_q * DW'(10) + DW'(cmd);
  assign bksp_d  = entry_q / DW'(10);
  assign add_d   = {1'b0, rega_q} + {1'b0, regb_q};

  // Shift-add multiplier: upper half accumulates, multiplier bits retire from the bottom.
  assign mul_hi = {1'b0, prod_q[2*DW-1:DW]} + (prod_q[0] ? {1'b0, rega_q} : '0);
  assign mul_d  = {mul_hi, prod_q[DW-1:1]};

`ifdef CALC_DIV_EN
  assign op_bad = 1'b0;
  logic [DW:0]   div_r;
  logic [DW+1:0] div_s;
  assign div_r = {prod_q[2*DW-1:DW], prod_q[DW-1]};
  assign div_s = {1'b0, div_r} - {2'b00, regb_q};
  assign div_d = div_s[DW+1] ? {div_r[DW-1:0], prod_q[DW-2:0], 1'b0}
                             : {div_s[DW-1:0], prod_q[DW-2:0], 1'b1};
`else
  assign op_bad = (cmd == OP_DIV);
  assign div_d  = '0;
`endif

  always_comb begin
    res_d     = '0;
    res_err_d = 1'b0;
    done_d    = 1'b0;
    case (op_q)
      OP_ADD: begin
        res_d     = add_d[DW-1:0];
        res_err_d = add_d > {1'b0, MAXV};
        done_d    = 1'b1;
      end
      OP_SUB: begin
        res_d     = rega_q - regb_q;
        res_err_d = rega_q < regb_q;
        done_d    = 1'b1;
      end
      OP_MUL: begin
        res_d     = mul_d[DW-1:0];
        res_err_d = (mul_d[2*DW-1:DW] != '0) || (mul_d[DW-1:0] > MAXV);
        done_d    = last_iter;
      end
      default: begin
        res_d     = div_d[DW-1:0];
        res_err_d = (regb_q == '0);
        done_d    = last_iter;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= ENTRY_A;
      ret_q    <= ENTRY_A;
      status_q <= ST_READY;
      data_q   <= '0;
      pos_q    <= '0;
      dv_q     <= 1'b0;
      rega_q   <= '0;
      regb_q   <= '0;
      entry_q  <= '0;
      scan_q   <= '0;
      op_q     <= '0;
      iter_q   <= '0;
      prod_q   <= '0;
      fresh_q  <= 1'b0;
    end else begin
      case (state_q)
        ENTRY_A, ENTRY_B: begin
          if (accept) begin
            status_q <= ST_BUSY;
            state_q  <= SCAN;
            ret_q    <= state_q;
            if (cmd <= 4'd9) begin
              entry_q <= digit_d;
              scan_q  <= digit_d;
              fresh_q <= 1'b0;
            end else if (cmd == C_BS) begin
              entry_q <= bksp_d;
              scan_q  <= bksp_d;
              fresh_q <= 1'b0;
            end else if (cmd == C_EQ) begin
              if (state_q == ENTRY_A) begin
                scan_q <= entry_q;
              end else begin
                regb_q  <= entry_q;
                iter_q  <= '0;
                state_q <= EXEC;
                prod_q  <= (op_q == OP_MUL) ? {{DW{1'b0}}, entry_q} : {{DW{1'b0}}, rega_q};
              end
            end else if (state_q == ENTRY_B || op_bad) begin
              state_q <= ERR;
            end else begin
              rega_q  <= entry_q;
              op_q    <= cmd;
              entry_q <= '0;
              scan_q  <= '0;
              fresh_q <= 1'b0;
              ret_q   <= ENTRY_B;
            end
          end
        end
        EXEC: begin
          iter_q <= iter_q + CW'(1);
          prod_q <= (op_q == OP_MUL) ? mul_d : div_d;
          if (done_d) begin
            if (res_err_d) begin
              state_q <= ERR;
            end else begin
              entry_q <= res_d;
              scan_q  <= res_d;
              fresh_q <= 1'b1;
              ret_q   <= ENTRY_A;
              state_q <= SCAN;
            end
          end
        end
        SCAN: begin
          if (dv_q && pos_q == PW'(NDIG - 1)) begin
            dv_q     <= 1'b0;
            status_q <= ST_READY;
            state_q  <= ret_q;
          end else begin
            data_q <= scan_dig;
            pos_q  <= dv_q ? pos_q + PW'(1) : '0;
            dv_q   <= 1'b1;
            scan_q <= scan_q / DW'(10);
          end
        end
        default: begin
          status_q <= ST_ERR;
          dv_q     <= 1'b0;
          data_q   <= 4'hF;
        end
      endcase
    end
  end

  assign status     = status_q;
  assign data       = data_q;
  assign pos        = pos_q;
  assign disp_valid = dv_q;

endmodule

// File: tb/tb_calc_n.sv
// Randomised and directed bench for calc_n against an arithmetic model of the calculator.
module tb_calc_n;
  localparam int NDIG = 8;
  localparam int DW   = 27;
  localparam int PW   = $clog2(NDIG);
`ifdef CALC_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset;
  logic [3:0]    cmd;
  logic          cmd_valid;
  logic [1:0]    status;
  logic [3:0]    data;
  logic [PW-1:0] pos;
  logic          disp_valid;

  calc_n #(.NDIG(NDIG), .DW(DW)) dut (
    .clock(clock), .reset(reset), .cmd(cmd), .cmd_valid(cmd_valid),
    .status(status), .data(data), .pos(pos), .disp_valid(disp_valid)
  );

  always #5 clock = ~clock;

  int vectors = 0;
  int errors  = 0;

  // Model: state 0 = first operand, 1 = second operand, 2 = error
  int     m_state;
  longint m_entry, m_rega;
  int     m_op;
  bit     m_fresh;
  int     exp_q[$];
  longint scan_acc, last_scan;
  int     mon_e;

  function automatic longint p10(input int n);
    longint v = 1;
    for (int i = 0; i < n; i++) v = v * 10;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (!reset) begin
      check("status_legal", status == 2'b11, 0);
      if (disp_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_digit", 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          check("scan_pos", pos, mon_e / 16);
          check("scan_digit", data, mon_e % 16);
        end
        scan_acc = (pos == 0) ? longint'(data) : scan_acc + longint'(data) * p10(int'(pos));
        if (pos == PW'(NDIG - 1)) last_scan = scan_acc;
      end
      if (status == 2'b00) begin
        check("err_outputs", {disp_valid, data}, 5'h0F);
        check("err_model_state", m_state, 2);
      end
    end
  end

  task automatic model_cmd(input int c, output int kind, output int lat);
    longint r;
    bit     bad;
    kind = 0;
    lat  = 1;
    if (c <= 9) begin
      if (m_fresh) m_entry = c;
      else if (m_entry < p10(NDIG - 1)) m_entry = m_entry * 10 + c;
      m_fresh = 0;
    end else if (c == 15) begin
      m_entry = m_entry / 10;
      m_fresh = 0;
    end else if (c == 14) begin
      if (m_state == 1) begin
        bad = 0;
        lat = (m_op >= 12) ? DW + 1 : 2;
        case (m_op)
          10: r = m_rega + m_entry;
          11: begin bad = m_rega < m_entry; r = m_rega - m_entry; end
          12: r = m_rega * m_entry;
          default: begin bad = (m_entry == 0); r = bad ? 0 : m_rega / m_entry; end
        endcase
        if (bad || r > p10(NDIG) - 1) begin
          kind = 1; m_state = 2;
        end else begin
          m_entry = r; m_state = 0; m_fresh = 1;
        end
      end
    end else begin
      if (m_state == 1 || (c == 13 && !DIV_EN)) begin
        kind = 1; m_state = 2;
      end else begin
        m_rega = m_entry; m_op = c; m_entry = 0; m_state = 1; m_fresh = 0;
      end
    end
    if (kind == 0)
      for (int i = 0; i < NDIG; i++) exp_q.push_back(i * 16 + int'((m_entry / p10(i)) % 10));
  endtask

  task automatic send(input int c);
    int kind, lat, n;
    bit seen;
    if (m_state == 2) begin
      @(negedge clock); cmd = 4'(c); cmd_valid = 1'b1;
      @(negedge clock); cmd_valid = 1'b0;
      repeat (2) @(negedge clock);
      check("err_sticky", status, 2'b00);
      return;
    end
    n = 0;
    while (status !== 2'b10 && n < 100) begin @(negedge clock); n++; end
    check("ready_before_cmd", status, 2'b10);
    model_cmd(c, kind, lat);
    cmd = 4'(c); cmd_valid = 1'b1;
    @(negedge clock); cmd_valid = 1'b0;
    check("busy_after_accept", status, 2'b01);
    n = 0; seen = 0;
    while (n < 200) begin
      @(negedge clock); n++;
      cmd_valid = 1'b0;
      if (disp_valid && !seen) begin seen = 1; check("scan_latency", n, lat); end
      if (status == 2'b10 || status == 2'b00) break;
      if ($urandom_range(3) == 0) begin cmd = 4'($urandom); cmd_valid = 1'b1; end
    end
    if (kind == 1) begin
      check("err_status", status, 2'b00);
    end else begin
      check("ready_after_scan", status, 2'b10);
      check("dv_low_after_scan", disp_valid, 0);
      check("scan_all_digits", exp_q.size(), 0);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_entry = 0; m_rega = 0; m_op = 0; m_fresh = 0;
    exp_q.delete();
  endtask

  task automatic do_reset();
    @(negedge clock); reset = 1'b1; cmd_valid = 1'b0; #1;
    check("rst_status", status, 2'b10);
    check("rst_dv", disp_valid, 0);
    check("rst_data", data, 0);
    check("rst_pos", pos, 0);
    @(negedge clock); reset = 1'b0;
    model_reset();
  endtask

  task automatic send_seq(input int s[$]);
    foreach (s[i]) send(s[i]);
  endtask

  initial begin
    int r, c;
    reset = 1'b1; cmd = '0; cmd_valid = 1'b0;
    model_reset();
    repeat (2) @(negedge clock);
    do_reset();

    send_seq('{1, 2, 10, 3, 4, 14});
    check("lit_12_plus_34", last_scan, 46);

    send_seq('{9, 9, 9, 12, 9, 9, 9, 14});
    check("lit_999_x_999", last_scan, 998001);

    do_reset();
    send_seq('{5, 11, 7, 14});
    check("lit_sub_neg_err", status, 2'b00);
    check("lit_err_data_F", data, 4'hF);
    send_seq('{3, 14, 15});
    check("lit_err_held", status, 2'b00);

    do_reset();
    send_seq('{9, 9, 9, 9, 9, 9, 9, 9, 9});
    check("lit_ninth_digit_dropped", last_scan, 99999999);
    send(15);
    check("lit_backspace", last_scan, 9999999);

`ifdef CALC_DIV_EN
    do_reset();
    send_seq('{1, 0, 0, 13, 7, 14});
    check("lit_100_div_7", last_scan, 14);
    do_reset();
    send_seq('{1, 13, 0, 14});
    check("lit_div_zero_err", status, 2'b00);
`else
    do_reset();
    send(13);
    check("lit_div_disabled_err", status, 2'b00);
`endif

    do_reset();
    send_seq('{9, 9, 9, 12, 9, 9, 9});
    @(negedge clock);
    cmd = 4'd14; cmd_valid = 1'b1;
    @(negedge clock); cmd_valid = 1'b0;
    repeat (10) @(negedge clock);
    reset = 1'b1; #1;
    check("mid_mul_rst_status", status, 2'b10);
    check("mid_mul_rst_dv", disp_valid, 0);
    @(negedge clock); reset = 1'b0;
    model_reset();
    send_seq('{2, 10, 2, 14});
    check("lit_2_plus_2", last_scan, 4);

    do_reset();
    repeat (250) begin
      if (m_state == 2) do_reset();
      r = $urandom_range(99);
      if (r < 60)      c = $urandom_range(9);
      else if (r < 70) c = 15;
      else if (r < 85) c = 14;
      else             c = (m_state == 1 && $urandom_range(3) != 0) ? 14 : $urandom_range(13, 10);
      send(c);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end
endmodule
